// File: rtl/motoro3_pkg.sv
// Shared motoro3 constants: counter widths, sequencer state encoding and the
// commutation-step wrap helper.
package motoro3_pkg;

    localparam int M3_SPD_W         = 25;
    localparam int M3_PWM_W         = 16;
    localparam int M3_STEP_W        = 4;
    localparam int M3_SPLIT_W       = 2;
    localparam int M3_STEP_LAST_DEF = 11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    // Next commutation step, wrapping between last and 0 in either direction.
    function automatic logic [M3_STEP_W-1:0] step_next(
        input logic [M3_STEP_W-1:0] step,
        input logic                 rev,
        input logic [M3_STEP_W-1:0] last
    );
        logic [M3_STEP_W-1:0] nxt;
        if (rev) begin
            nxt = (step == '0) ? last : step - 4'd1;
        end else begin
            nxt = (step == last) ? '0 : step + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/motoro3_pwm_period_counter.sv
// PWM period position counter; period length is latched only when a new
// period starts, so mid-period length changes never truncate a period.
module motoro3_pwm_period_counter
    import motoro3_pkg::*;
(
    input  logic                clk,
    input  logic                nRST,
    input  logic                active_d,
    input  logic                restart,
    input  logic [M3_PWM_W-1:0] len_in,
    output logic [M3_PWM_W-1:0] cnt,
    output logic                period_start,
    output logic                period_last
);

    logic [M3_PWM_W-1:0] cnt_q, cnt_d;
    logic [M3_PWM_W-1:0] len_q, len_d;
    logic                start_q, start_d;

    always_comb begin
        period_last = (cnt_q == len_q - 16'd1);
        cnt_d       = cnt_q;
        len_d       = len_q;
        start_d     = 1'b0;
        if (!active_d) begin
            cnt_d = '0;
        end else if (restart || period_last) begin
            cnt_d   = '0;
            start_d = 1'b1;
            len_d   = (len_in == '0) ? 16'd1 : len_in;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q   <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            start_q <= start_d;
        end
    end

    assign cnt          = cnt_q;
    assign period_start = start_q;

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Motor commutation step sequencer: split-step timing, step direction and
// PWM period framing for the line-calc block.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | stopped; step/split frozen, PWM and speed counters cleared
// ST_RUN      | stepping and PWM running
// ST_STOPPING | stop requested; keeps stepping until the PWM period ends
module motoro3_step_sequencer
    import motoro3_pkg::*;
#(
    parameter int STEP_LAST = M3_STEP_LAST_DEF
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  m3r_run,
    input  logic                  m3r_dirRev,
    input  logic [M3_SPD_W-1:0]   m3r_stepCNT_speedSET,
    input  logic [M3_SPLIT_W-1:0] m3r_stepSplitMax,
    input  logic [M3_PWM_W-1:0]   pwmLENpos,
    output logic [M3_STEP_W-1:0]  lcStep,
    output logic [M3_SPLIT_W-1:0] m3LpwmSplitStep,
    output logic [M3_PWM_W-1:0]   pwmCNT,
    output logic                  pwmPeriodStart,
    output logic                  stepAdvance,
    output logic                  seqBusy
);

    localparam logic [M3_STEP_W-1:0] STEP_LAST_V = M3_STEP_W'(STEP_LAST);

    logic [1:0]            state_q, state_d;
    logic [M3_STEP_W-1:0]  step_q, step_d;
    logic [M3_SPLIT_W-1:0] split_q, split_d;
    logic [M3_SPD_W-1:0]   spd_q, spd_d;
    logic [M3_SPD_W-1:0]   spd_sh_q, spd_sh_d;
    logic [M3_SPLIT_W-1:0] split_sh_q, split_sh_d;
    logic                  step_adv_q, step_adv_d;
    logic                  busy_q, busy_d;

    logic [M3_SPD_W-1:0]   spd_last;
    logic                  restart;
    logic                  tick;
    logic                  boundary;
    logic                  period_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (m3r_run) state_d = ST_RUN;
            ST_RUN:      if (!m3r_run) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (m3r_run)          state_d = ST_RUN;
                else if (period_last) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // A split index at or above the shadowed max always ends the step.
    always_comb begin
        restart    = (state_q == ST_IDLE) && (state_d != ST_IDLE);
        spd_last   = (spd_sh_q == '0) ? '0 : spd_sh_q - 25'd1;
        tick       = (state_q != ST_IDLE) && (spd_q == spd_last);
        boundary   = tick && !(split_q < split_sh_q);

        spd_d      = spd_q + 25'd1;
        if ((state_d == ST_IDLE) || restart || tick) spd_d = '0;

        split_d    = split_q;
        step_d     = step_q;
        if (boundary) begin
            split_d = '0;
            step_d  = step_next(step_q, m3r_dirRev, STEP_LAST_V);
        end else if (tick) begin
            split_d = split_q + 2'd1;
        end

        spd_sh_d   = spd_sh_q;
        split_sh_d = split_sh_q;
        if (restart || boundary) begin
            spd_sh_d   = m3r_stepCNT_speedSET;
            split_sh_d = m3r_stepSplitMax;
        end

        step_adv_d = boundary;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            split_q    <= '0;
            spd_q      <= '0;
            spd_sh_q   <= '0;
            split_sh_q <= '0;
            step_adv_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            split_q    <= split_d;
            spd_q      <= spd_d;
            spd_sh_q   <= spd_sh_d;
            split_sh_q <= split_sh_d;
            step_adv_q <= step_adv_d;
            busy_q     <= busy_d;
        end
    end

    motoro3_pwm_period_counter u_pwm_cnt (
        .clk          (clk),
        .nRST         (nRST),
        .active_d     (state_d != ST_IDLE),
        .restart      (restart),
        .len_in       (pwmLENpos),
        .cnt          (pwmCNT),
        .period_start (pwmPeriodStart),
        .period_last  (period_last)
    );

    assign lcStep          = step_q;
    assign m3LpwmSplitStep = split_q;
    assign stepAdvance     = step_adv_q;
    assign seqBusy         = busy_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed bench for the motoro3 step sequencer; inputs change and outputs
// are sampled on the falling clock edge.
module tb_motoro3_step_sequencer;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        m3r_run = 1'b0;
    logic        m3r_dirRev = 1'b0;
    logic [24:0] m3r_stepCNT_speedSET = 25'd4;
    logic [1:0]  m3r_stepSplitMax = 2'd0;
    logic [15:0] pwmLENpos = 16'd100;
    logic [3:0]  lcStep;
    logic [1:0]  m3LpwmSplitStep;
    logic [15:0] pwmCNT;
    logic        pwmPeriodStart;
    logic        stepAdvance;
    logic        seqBusy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motoro3_step_sequencer dut (
        .clk                  (clk),
        .nRST                 (nRST),
        .m3r_run              (m3r_run),
        .m3r_dirRev           (m3r_dirRev),
        .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
        .m3r_stepSplitMax     (m3r_stepSplitMax),
        .pwmLENpos            (pwmLENpos),
        .lcStep               (lcStep),
        .m3LpwmSplitStep      (m3LpwmSplitStep),
        .pwmCNT               (pwmCNT),
        .pwmPeriodStart       (pwmPeriodStart),
        .stepAdvance          (stepAdvance),
        .seqBusy              (seqBusy)
    );

    task do_reset;
        m3r_run = 1'b0;
        nRST    = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
    endtask

    task test_reset;
        #1;
        checks++;
        if ({lcStep, m3LpwmSplitStep, pwmCNT, pwmPeriodStart, stepAdvance, seqBusy} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got step=%0d split=%0d cnt=%0d start=%b adv=%b busy=%b, want all 0",
                     lcStep, m3LpwmSplitStep, pwmCNT, pwmPeriodStart, stepAdvance, seqBusy);
        end
        do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (seqBusy !== 1'b0 || pwmCNT !== 16'd0 || pwmPeriodStart !== 1'b0 || lcStep !== 4'd0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b cnt=%0d start=%b step=%0d, want 0 0 0 0",
                     seqBusy, pwmCNT, pwmPeriodStart, lcStep);
        end
    endtask

    task test_reset_release_run;
        nRST    = 1'b0;
        m3r_run = 1'b1;
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        checks++;
        if (seqBusy !== 1'b1 || pwmPeriodStart !== 1'b1 || pwmCNT !== 16'd0) begin
            errors++;
            $display("FAIL release_run_first: got busy=%b start=%b cnt=%0d, want 1 1 0",
                     seqBusy, pwmPeriodStart, pwmCNT);
        end
        @(negedge clk);
        checks++;
        if (pwmPeriodStart !== 1'b0 || pwmCNT !== 16'd1) begin
            errors++;
            $display("FAIL release_run_second: got start=%b cnt=%0d, want 0 1", pwmPeriodStart, pwmCNT);
        end
    endtask

    task test_split_fwd;
        int es, ep, ec;
        logic ea, est;
        m3r_stepCNT_speedSET = 25'd4;
        m3r_stepSplitMax     = 2'd2;
        pwmLENpos            = 16'd12;
        m3r_dirRev           = 1'b0;
        do_reset();
        m3r_run = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            ep  = (c / 4) % 3;
            es  = c / 12;
            ea  = (c > 0) && (c % 12 == 0);
            ec  = c % 12;
            est = (ec == 0);
            checks++;
            if (lcStep !== 4'(es) || m3LpwmSplitStep !== 2'(ep) || stepAdvance !== ea) begin
                errors++;
                $display("FAIL split_fwd c=%0d: got step=%0d split=%0d adv=%b, want %0d %0d %b",
                         c, lcStep, m3LpwmSplitStep, stepAdvance, es, ep, ea);
            end
            checks++;
            if (pwmCNT !== 16'(ec) || pwmPeriodStart !== est || seqBusy !== 1'b1) begin
                errors++;
                $display("FAIL split_fwd_pwm c=%0d: got cnt=%0d start=%b busy=%b, want %0d %b 1",
                         c, pwmCNT, pwmPeriodStart, seqBusy, ec, est);
            end
        end
    endtask

    task test_rev;
        int exp_r [6] = '{0, 11, 10, 9, 10, 11};
        m3r_stepCNT_speedSET = 25'd1;
        m3r_stepSplitMax     = 2'd0;
        pwmLENpos            = 16'd100;
        m3r_dirRev           = 1'b1;
        do_reset();
        m3r_run = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (lcStep !== 4'(exp_r[c]) || stepAdvance !== (c > 0) || m3LpwmSplitStep !== 2'd0) begin
                errors++;
                $display("FAIL rev_step c=%0d: got step=%0d adv=%b split=%0d, want %0d %b 0",
                         c, lcStep, stepAdvance, m3LpwmSplitStep, exp_r[c], c > 0);
            end
            if (c == 3) m3r_dirRev = 1'b0;
        end
    endtask

    task test_pwm_len;
        int ec;
        m3r_stepCNT_speedSET = 25'd1000;
        m3r_stepSplitMax     = 2'd0;
        pwmLENpos            = 16'd5;
        do_reset();
        m3r_run = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            if (c < 15)      ec = c % 5;
            else if (c < 21) ec = (c - 15) % 3;
            else             ec = 0;
            checks++;
            if (pwmCNT !== 16'(ec) || pwmPeriodStart !== (ec == 0)) begin
                errors++;
                $display("FAIL pwm_len c=%0d: got cnt=%0d start=%b, want %0d %b",
                         c, pwmCNT, pwmPeriodStart, ec, ec == 0);
            end
            if (c == 12) pwmLENpos = 16'd3;
            if (c == 18) pwmLENpos = 16'd0;
        end
    endtask

    task test_stop;
        int ec, es;
        logic eb, ea;
        m3r_stepCNT_speedSET = 25'd2;
        m3r_stepSplitMax     = 2'd0;
        pwmLENpos            = 16'd5;
        m3r_dirRev           = 1'b0;
        do_reset();
        m3r_run = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            eb = (c <= 4);
            ec = (c <= 4) ? c : 0;
            es = (c < 2) ? 0 : ((c < 4) ? 1 : 2);
            ea = (c == 2) || (c == 4);
            checks++;
            if (seqBusy !== eb || pwmCNT !== 16'(ec) || lcStep !== 4'(es) ||
                stepAdvance !== ea || pwmPeriodStart !== (c == 0)) begin
                errors++;
                $display("FAIL stop_idle c=%0d: got busy=%b cnt=%0d step=%0d adv=%b start=%b, want %b %0d %0d %b %b",
                         c, seqBusy, pwmCNT, lcStep, stepAdvance, pwmPeriodStart, eb, ec, es, ea, c == 0);
            end
            if (c == 1) m3r_run = 1'b0;
        end
        do_reset();
        m3r_run = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (seqBusy !== 1'b1 || pwmCNT !== 16'(c % 5) || pwmPeriodStart !== (c % 5 == 0)) begin
                errors++;
                $display("FAIL stop_resume c=%0d: got busy=%b cnt=%0d start=%b, want 1 %0d %b",
                         c, seqBusy, pwmCNT, pwmPeriodStart, c % 5, c % 5 == 0);
            end
            if (c == 1) m3r_run = 1'b0;
            if (c == 3) m3r_run = 1'b1;
        end
    endtask

    task test_async_reset;
        m3r_stepCNT_speedSET = 25'd1;
        m3r_stepSplitMax     = 2'd0;
        pwmLENpos            = 16'd100;
        m3r_dirRev           = 1'b0;
        do_reset();
        m3r_run = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (lcStep !== 4'd7 || seqBusy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got step=%0d busy=%b, want 7 1", lcStep, seqBusy);
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({lcStep, m3LpwmSplitStep, pwmCNT, pwmPeriodStart, stepAdvance, seqBusy} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset: got step=%0d split=%0d cnt=%0d start=%b adv=%b busy=%b, want all 0",
                     lcStep, m3LpwmSplitStep, pwmCNT, pwmPeriodStart, stepAdvance, seqBusy);
        end
        m3r_run = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
    endtask

    task test_speed_change;
        int es;
        logic ea;
        m3r_stepCNT_speedSET = 25'd4;
        m3r_stepSplitMax     = 2'd0;
        pwmLENpos            = 16'd100;
        m3r_dirRev           = 1'b0;
        do_reset();
        m3r_run = 1'b1;
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            es = (c < 4) ? 0 : ((c < 12) ? 1 : ((c < 20) ? 2 : 3));
            ea = (c == 4) || (c == 12) || (c == 20);
            checks++;
            if (lcStep !== 4'(es) || stepAdvance !== ea) begin
                errors++;
                $display("FAIL speed_change c=%0d: got step=%0d adv=%b, want %0d %b",
                         c, lcStep, stepAdvance, es, ea);
            end
            if (c == 2) m3r_stepCNT_speedSET = 25'd8;
        end
    endtask

    initial begin
        test_reset();
        test_reset_release_run();
        test_split_fwd();
        test_rev();
        test_pwm_len();
        test_stop();
        test_async_reset();
        test_speed_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
